div32_seq: RTL and testbench

DIV32_SEQ -- requirements
Module: div32_seq

---
 rtl/div32_if.sv | 24 ++
 rtl/div32_seq.sv | 116 +++++++++++
 tb/tb_div32_seq.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/div32_if.sv
// Handshake and result bundle for the sequential divider.
// The divider takes the slave modport; whoever issues the divisions takes the master modport.
interface div32_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div32_seq.sv
// Unsigned restoring divider: one quotient bit per clock, WIDTH steps per division.
// Results are copied to the output registers in the cycle after the internal DONE state.
module div32_seq #(
  parameter int WIDTH = 32
) (
  input  logic   clk,
  input  logic   rst,
  div32_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] div_q;
  logic             dbzPend_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quotOut_q;
  logic [WIDTH-1:0] remOut_q;
  logic             dbz_q;

  logic             accept;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diffWide;
  logic             trialOk;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;

  assign accept = bus.start && ((state_q == IDLE) || (state_q == DONE));

  // Restoring step: a clear top bit of the widened difference means the trial subtraction fits.
  always_comb begin
    shifted  = {rem_q, quo_q[WIDTH-1]};
    diffWide = {1'b0, shifted} - {2'b00, div_q};
    trialOk  = ~diffWide[WIDTH+1];
    rem_d    = trialOk ? diffWide[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_d    = {quo_q[WIDTH-2:0], trialOk};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      dbzPend_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      quotOut_q <= '0;
      remOut_q  <= '0;
      dbz_q     <= 1'b0;
    end else begin
      busy_q <= (state_q == RUN);
      done_q <= (state_q == DONE);

      // Publishing a finished result takes priority over the flag clear of a back-to-back accept.
      if (state_q == DONE) begin
        quotOut_q <= quo_q;
        remOut_q  <= rem_q;
        dbz_q     <= dbzPend_q;
      end else if (accept) begin
        dbz_q <= 1'b0;
      end

      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            div_q <= bus.divisor;
            cnt_q <= '0;
            if (bus.divisor == '0) begin
              rem_q     <= bus.dividend;
              quo_q     <= '1;
              dbzPend_q <= 1'b1;
              state_q   <= DONE;
            end else begin
              rem_q     <= '0;
              quo_q     <= bus.dividend;
              dbzPend_q <= 1'b0;
              state_q   <= RUN;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= DONE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quotOut_q;
  assign bus.remainder   = remOut_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_div32_seq.sv
// Bench for div32_seq: an edge-counting model built on / and % is checked against the outputs every cycle,
// alongside directed divisions with literal results, a start ignored mid-run, back-to-back starts and an abort.
module tb_div32_seq;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  div32_if #(.WIDTH(32)) dif ();

  div32_seq #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: an accept at edge k is announced at edge k+33, or at k+1 for a zero divisor.
  int          edgeN    = 0;
  int          readyAt  = 0;
  int          doneAt   = -1;
  int          busyFrom = -1;
  int          busyTo   = -2;
  logic [31:0] mQ = '0, mR = '0, pQ = '0, pR = '0;
  logic        mDbz = 1'b0, pDbz = 1'b0, mDone = 1'b0, mBusy = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      readyAt  = 0;
      doneAt   = -1;
      busyFrom = -1;
      busyTo   = -2;
      mQ = '0; mR = '0; mDbz = 1'b0; mDone = 1'b0; mBusy = 1'b0;
    end else begin
      edgeN++;
      mDone = 1'b0;
      if (edgeN == doneAt) begin
        mQ = pQ; mR = pR; mDbz = pDbz; mDone = 1'b1;
      end
      if (dif.start && edgeN >= readyAt) begin
        if (!mDone) mDbz = 1'b0;
        if (dif.divisor == 32'd0) begin
          pQ = 32'hFFFF_FFFF; pR = dif.dividend; pDbz = 1'b1;
          doneAt = edgeN + 1; busyFrom = -1; busyTo = -2;
        end else begin
          pQ = dif.dividend / dif.divisor; pR = dif.dividend % dif.divisor; pDbz = 1'b0;
          doneAt = edgeN + 33; busyFrom = edgeN + 1; busyTo = edgeN + 32;
        end
        readyAt = doneAt;
      end
      mBusy = (edgeN >= busyFrom) && (edgeN <= busyTo);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("busy", 32'(dif.busy), 32'(mBusy));
    checkOutput("done", 32'(dif.done), 32'(mDone));
    checkOutput("quotient", dif.quotient, mQ);
    checkOutput("remainder", dif.remainder, mR);
    checkOutput("divByZero", 32'(dif.div_by_zero), 32'(mDbz));
  end

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    dif.start = 1'b1; dif.dividend = a; dif.divisor = b;
    @(negedge clk);
    dif.start = 1'b0;
  endtask

  task automatic waitDone(input int pulseAt, input logic [31:0] pa, input logic [31:0] pb, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (cycles == pulseAt) begin
        dif.start = 1'b1; dif.dividend = pa; dif.divisor = pb;
      end else begin
        dif.start = 1'b0;
      end
    end while (!dif.done && cycles < 100);
    if (!dif.done) checkOutput("doneTimeout", 32'd0, 32'd1);
  endtask

  task automatic runOp(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q,
                       input logic [31:0] r, input logic z, input int lat);
    int cyc;
    applyStimulus(a, b);
    waitDone(0, '0, '0, cyc);
    checkOutput("latency", 32'(cyc), 32'(lat));
    checkOutput("litQuotient", dif.quotient, q);
    checkOutput("litRemainder", dif.remainder, r);
    checkOutput("litDivByZero", 32'(dif.div_by_zero), 32'(z));
  endtask

  logic [31:0] tA [6] = '{32'd100, 32'd54565, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5};
  logic [31:0] tB [6] = '{32'd7, 32'd4565, 32'd10, 32'd1, 32'hFFFF_FFFF, 32'd0};
  logic [31:0] tQ [6] = '{32'd14, 32'd11, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF};
  logic [31:0] tR [6] = '{32'd2, 32'd4350, 32'd3, 32'd0, 32'd0, 32'd5};
  logic        tZ [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  int          tL [6] = '{33, 33, 33, 33, 33, 1};

  initial begin
    int cyc;
    rst = 1'b1;
    dif.start = 1'b0; dif.dividend = '0; dif.divisor = '0;
    repeat (3) @(negedge clk);
    checkOutput("resetQuotient", dif.quotient, 32'd0);
    checkOutput("resetBusy", 32'(dif.busy), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      runOp(tA[i], tB[i], tQ[i], tR[i], tZ[i], tL[i]);
    end

    // A second start ten cycles into a run must be dropped.
    applyStimulus(32'd1000, 32'd3);
    waitDone(10, 32'd77, 32'd5, cyc);
    checkOutput("ignoredLatency", 32'(cyc), 32'd33);
    checkOutput("ignoredQuotient", dif.quotient, 32'd333);
    checkOutput("ignoredRemainder", dif.remainder, 32'd1);

    // Start held high straight through: the second division is taken in the DONE state.
    @(negedge clk);
    dif.start = 1'b1; dif.dividend = 32'd100; dif.divisor = 32'd7;
    @(negedge clk);
    dif.dividend = 32'd54565; dif.divisor = 32'd4565;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!dif.done && cyc < 100);
    dif.start = 1'b0;
    checkOutput("b2bFirstLatency", 32'(cyc), 32'd33);
    checkOutput("b2bFirstQuotient", dif.quotient, 32'd14);
    checkOutput("b2bFirstRemainder", dif.remainder, 32'd2);
    waitDone(0, '0, '0, cyc);
    checkOutput("b2bSecondLatency", 32'(cyc), 32'd33);
    checkOutput("b2bSecondQuotient", dif.quotient, 32'd11);
    checkOutput("b2bSecondRemainder", dif.remainder, 32'd4350);

    // Abort twenty cycles into a run, between clock edges.
    applyStimulus(32'd100, 32'd7);
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("abortBusy", 32'(dif.busy), 32'd0);
    checkOutput("abortQuotient", dif.quotient, 32'd0);
    checkOutput("abortRemainder", dif.remainder, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      checkOutput("abortNoDone", 32'(dif.done), 32'd0);
    end
    runOp(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);

    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      dif.start = ($urandom_range(0, 5) == 0);
      dif.dividend = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 200)) : $urandom;
      case ($urandom_range(0, 5))
        0:       dif.divisor = 32'd0;
        1, 2:    dif.divisor = 32'($urandom_range(1, 16));
        default: dif.divisor = $urandom;
      endcase
    end
    @(negedge clk);
    dif.start = 1'b0;
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
